// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The default reset PC lives here so the top and the PC register agree on it.
package if_fetch_stage_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_stage_pc_reg.sv
// Program counter register: async reset, hold, load, and an incrementer that
// only acts on the low PC_INC_BITS bits (carry out of that field is dropped).
module if_pc_reg
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          PC_INC_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [31:0] i_load_addr,
  input  logic        i_inc,
  output logic [31:0] o_pc
);

  logic [31:0]            r_pc;
  logic [PC_INC_BITS-1:0] w_low_inc;
  logic [31:0]            w_pc_inc;

  assign w_low_inc = r_pc[PC_INC_BITS-1:0] + PC_INC_BITS'(4);
  assign w_pc_inc  = {r_pc[31:PC_INC_BITS], w_low_inc};

  // Load (redirect) has priority over increment; neither means hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_load_addr;
    end else if (i_inc) begin
      r_pc <= w_pc_inc;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the IM address, and fills IF/ID,
// inserting NOP bubbles after a redirect and counting valid fetches.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = RESET_PC_DEFAULT,
  parameter int          PC_INC_BITS   = 8,
  parameter int          FLUSH_BUBBLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_pc_write,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_addr,
  output logic [31:0] o_im_addr,
  input  logic [31:0] i_im_instr,
  output logic        o_if_id_valid,
  output logic [31:0] o_if_id_instr,
  output logic [31:0] o_if_id_pc,
  output logic [31:0] o_fetch_count,
  output logic        o_misalign_err
);

  localparam logic [1:0] CNT_INIT = 2'(FLUSH_BUBBLES - 1);

  fetch_state_t r_state, w_state_next;
  logic [1:0]   r_cnt, w_cnt_next;
  logic         r_if_id_valid;
  logic [31:0]  r_if_id_instr;
  logic [31:0]  r_if_id_pc;
  logic [31:0]  r_fetch_count;
  logic         r_misalign;
  logic [31:0]  w_pc;
  logic         w_pc_load;
  logic         w_pc_inc;
  logic         w_load_bubble;
  logic         w_load_instr;

  if_pc_reg #(
    .RESET_PC    (RESET_PC),
    .PC_INC_BITS (PC_INC_BITS)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_pc_load),
    .i_load_addr ({i_redirect_addr[31:2], 2'b00}),
    .i_inc       (w_pc_inc),
    .o_pc        (w_pc)
  );

  // A redirect is honoured in every state and always (re)starts the flush.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_pc_load     = 1'b0;
    w_pc_inc      = 1'b0;
    w_load_bubble = 1'b0;
    w_load_instr  = 1'b0;
    if (i_redirect_valid) begin
      w_pc_load     = 1'b1;
      w_load_bubble = 1'b1;
      w_cnt_next    = CNT_INIT;
      w_state_next  = (FLUSH_BUBBLES > 1) ? FLUSH : RUN;
    end else begin
      case (r_state)
        BOOT: begin
          w_load_bubble = 1'b1;
          w_state_next  = RUN;
        end
        RUN: begin
          if (i_pc_write) begin
            w_pc_inc     = 1'b1;
            w_load_instr = 1'b1;
          end
        end
        FLUSH: begin
          // Bubbles ignore stalls; leave once this is the last one.
          w_load_bubble = 1'b1;
          w_cnt_next    = r_cnt - 2'd1;
          if (r_cnt <= 2'd1) begin
            w_cnt_next   = 2'd0;
            w_state_next = RUN;
          end
        end
        default: begin
          w_state_next = BOOT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= BOOT;
      r_cnt         <= 2'd0;
      r_if_id_valid <= 1'b0;
      r_if_id_instr <= NOP_INSTR;
      r_if_id_pc    <= 32'h0;
      r_fetch_count <= 32'h0;
      r_misalign    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_load_bubble) begin
        r_if_id_valid <= 1'b0;
        r_if_id_instr <= NOP_INSTR;
        r_if_id_pc    <= 32'h0;
      end else if (w_load_instr) begin
        r_if_id_valid <= 1'b1;
        r_if_id_instr <= i_im_instr;
        r_if_id_pc    <= w_pc;
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (i_redirect_valid && (i_redirect_addr[1:0] != 2'b00)) begin
        r_misalign <= 1'b1;
      end
    end
  end

  assign o_im_addr      = w_pc;
  assign o_if_id_valid  = r_if_id_valid;
  assign o_if_id_instr  = r_if_id_instr;
  assign o_if_id_pc     = r_if_id_pc;
  assign o_fetch_count  = r_fetch_count;
  assign o_misalign_err = r_misalign;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage (two-bubble flush): boot, sequential fetch,
// stall, redirect, PC wrap, misaligned redirect and asynchronous reset mid-flush.
module tb_if_fetch_stage;

  localparam logic [31:0] TAG = 32'hC0DE_0000;

  logic        clk;
  logic        rst;
  logic        i_pc_write;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_addr;
  logic [31:0] o_im_addr;
  logic [31:0] i_im_instr;
  logic        o_if_id_valid;
  logic [31:0] o_if_id_instr;
  logic [31:0] o_if_id_pc;
  logic [31:0] o_fetch_count;
  logic        o_misalign_err;

  int total_cnt = 0;
  int bad_cnt   = 0;

  if_fetch_stage #(
    .RESET_PC      (32'h0000_0000),
    .PC_INC_BITS   (8),
    .FLUSH_BUBBLES (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_pc_write       (i_pc_write),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_addr  (i_redirect_addr),
    .o_im_addr        (o_im_addr),
    .i_im_instr       (i_im_instr),
    .o_if_id_valid    (o_if_id_valid),
    .o_if_id_instr    (o_if_id_instr),
    .o_if_id_pc       (o_if_id_pc),
    .o_fetch_count    (o_fetch_count),
    .o_misalign_err   (o_misalign_err)
  );

  // Instruction memory: tagged address as data, so each fetch is identifiable.
  assign i_im_instr = o_im_addr ^ TAG;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic [31:0] im, input logic v,
                            input logic [31:0] pc, input logic [31:0] cnt, input logic mis);
    check_eq({tag, ".im_addr"}, o_im_addr, im);
    check_eq({tag, ".valid"}, {31'b0, o_if_id_valid}, {31'b0, v});
    check_eq({tag, ".instr"}, o_if_id_instr, v ? (pc ^ TAG) : 32'h0);
    check_eq({tag, ".pc"}, o_if_id_pc, v ? pc : 32'h0);
    check_eq({tag, ".count"}, o_fetch_count, cnt);
    check_eq({tag, ".misalign"}, {31'b0, o_misalign_err}, {31'b0, mis});
  endtask

  initial begin
    rst = 1'b1;
    i_pc_write = 1'b1;
    i_redirect_valid = 1'b0;
    i_redirect_addr = 32'h0;
    #12;
    expect_all("reset", 32'h0, 1'b0, 32'h0, 0, 1'b0);
    step();
    rst = 1'b0;

    // BOOT bubble, then sequential fetch 0,4,8,C
    step(); expect_all("boot", 32'h0, 1'b0, 32'h0, 0, 1'b0);
    step(); expect_all("seq0", 32'h4, 1'b1, 32'h0, 1, 1'b0);
    step(); expect_all("seq1", 32'h8, 1'b1, 32'h4, 2, 1'b0);
    step(); expect_all("seq2", 32'hC, 1'b1, 32'h8, 3, 1'b0);
    step(); expect_all("seq3", 32'h10, 1'b1, 32'hC, 4, 1'b0);

    // Stall three cycles at PC=0x10
    i_pc_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); expect_all($sformatf("stall%0d", i), 32'h10, 1'b1, 32'hC, 4, 1'b0);
    end

    // Redirect during stall: two bubbles, then target fetched
    i_redirect_valid = 1'b1; i_redirect_addr = 32'h40;
    step(); expect_all("redir.b0", 32'h40, 1'b0, 32'h0, 4, 1'b0);
    i_redirect_valid = 1'b0;
    step(); expect_all("redir.b1", 32'h40, 1'b0, 32'h0, 4, 1'b0);
    i_pc_write = 1'b1;
    step(); expect_all("redir.tgt", 32'h44, 1'b1, 32'h40, 5, 1'b0);

    // Low-field wrap: 0x1FC advances to 0x100
    i_redirect_valid = 1'b1; i_redirect_addr = 32'h1FC;
    step(); expect_all("wrap.b0", 32'h1FC, 1'b0, 32'h0, 5, 1'b0);
    i_redirect_valid = 1'b0;
    step(); expect_all("wrap.b1", 32'h1FC, 1'b0, 32'h0, 5, 1'b0);
    step(); expect_all("wrap.fc", 32'h100, 1'b1, 32'h1FC, 6, 1'b0);
    step(); expect_all("wrap.100", 32'h104, 1'b1, 32'h100, 7, 1'b0);

    // Misaligned redirect: aligned target, sticky error
    i_redirect_valid = 1'b1; i_redirect_addr = 32'h43;
    step(); expect_all("mis.b0", 32'h40, 1'b0, 32'h0, 7, 1'b1);
    i_redirect_valid = 1'b0;
    step(); expect_all("mis.b1", 32'h40, 1'b0, 32'h0, 7, 1'b1);
    step(); expect_all("mis.tgt", 32'h44, 1'b1, 32'h40, 8, 1'b1);
    step(); expect_all("mis.stk", 32'h48, 1'b1, 32'h44, 9, 1'b1);

    // Async reset in the middle of a flush
    i_redirect_valid = 1'b1; i_redirect_addr = 32'h80;
    step(); expect_all("pre_rst", 32'h80, 1'b0, 32'h0, 9, 1'b1);
    i_redirect_valid = 1'b0;
    #2 rst = 1'b1;
    #1 expect_all("async_rst", 32'h0, 1'b0, 32'h0, 0, 1'b0);
    step(); expect_all("rst_hold", 32'h0, 1'b0, 32'h0, 0, 1'b0);
    rst = 1'b0;
    step(); expect_all("reboot", 32'h0, 1'b0, 32'h0, 0, 1'b0);
    step(); expect_all("reboot.seq0", 32'h4, 1'b1, 32'h0, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
